// File: rtl/montgomery_pkg.sv
// Shared definitions for the Montgomery multiplier and its adder.
package montgomery_pkg;

    // Width of the shared multi-precision adder operands.
    localparam int ADDER_W = 1027;

    // Multiplier sequencing states.
    typedef enum logic [2:0] {
        IDLE,
        CHK_A,
        ADD_B,
        CHK_C,
        ADD_M,
        SHIFT,
        FINAL,
        DONE
    } state_t;

endpackage

// File: rtl/mpadder.sv
// Multi-precision adder/subtractor with a start/done handshake.
// The result is registered one cycle after start. Bit ADDER_W of a
// subtraction is the borrow.
module mpadder
    import montgomery_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               subtract,
    input  logic [ADDER_W-1:0] in_a,
    input  logic [ADDER_W-1:0] in_b,
    output logic [ADDER_W:0]   result,
    output logic               done
);

    // Register the sum or difference on start and pulse done for one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result <= '0;
            done   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register update
            // on the clock edge, independent of statement order.
            done <= start;
            if (start) begin
                if (subtract) result <= {1'b0, in_a} - {1'b0, in_b};
                else          result <= {1'b0, in_a} + {1'b0, in_b};
            end
        end
    end

endmodule

// File: rtl/montgomery_mul.sv
// Radix-2 bit-serial Montgomery multiplier: result = a*b*2^(-N) mod m.
// Every addition, modulus addition and the final subtraction go through
// one shared mpadder. The accumulator, shifter and control stay here.
module montgomery_mul
    import montgomery_pkg::*;
#(
    parameter int N = 1024
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] in_a,
    input  logic [N-1:0] in_b,
    input  logic [N-1:0] in_m,
    output logic [N-1:0] result,
    output logic         done,
    output logic         busy
);

    localparam int CNT_W = $clog2(N);

    state_t             state;
    state_t             next_state;
    logic [N-1:0]       a_q;
    logic [N-1:0]       b_q;
    logic [N-1:0]       m_q;
    logic [N+1:0]       c_q;
    logic [CNT_W-1:0]   bit_idx;
    logic               last_bit;

    logic               add_start;
    logic               add_sub;
    logic               add_done;
    logic [ADDER_W-1:0] add_a;
    logic [ADDER_W-1:0] add_b;
    logic [ADDER_W:0]   add_res;
    logic               unused_add_bits;

    assign last_bit = (bit_idx == CNT_W'(N - 1));
    assign busy     = (state != IDLE) && (state != DONE);
    assign done     = (state == DONE);

    // Adder operands are decoded from the state, so they stay stable for
    // the whole wait state that follows each start pulse. In SHIFT the
    // shifted accumulator is presented, and FINAL then holds that value
    // in c_q.
    assign add_a   = (state == SHIFT) ? ADDER_W'(c_q >> 1) : ADDER_W'(c_q);
    assign add_b   = (state == CHK_A || state == ADD_B) ? ADDER_W'(b_q) : ADDER_W'(m_q);
    assign add_sub = (state == SHIFT) || (state == FINAL);

    // Sums never reach the top adder bits; only the borrow and N+2 low bits matter.
    assign unused_add_bits = ^add_res[ADDER_W-1:N+2];

    mpadder u_adder (
        .clk      (clk),
        .rst_n    (~reset),
        .start    (add_start),
        .subtract (add_sub),
        .in_a     (add_a),
        .in_b     (add_b),
        .result   (add_res),
        .done     (add_done)
    );

    // State register; reset aborts any operation without a done pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // Next-state decode and the single adder start pulse per request.
    always_comb begin
        // NOTE: defaults first, so no path leaves a signal unassigned and
        // no latch is inferred.
        next_state = state;
        add_start  = 1'b0;
        unique case (state)
            IDLE:  if (start) next_state = CHK_A;
            CHK_A: begin
                if (a_q[bit_idx]) begin
                    add_start  = 1'b1;
                    next_state = ADD_B;
                end else begin
                    next_state = CHK_C;
                end
            end
            ADD_B: if (add_done) next_state = CHK_C;
            CHK_C: begin
                if (c_q[0]) begin
                    add_start  = 1'b1;
                    next_state = ADD_M;
                end else begin
                    next_state = SHIFT;
                end
            end
            ADD_M: if (add_done) next_state = SHIFT;
            SHIFT: begin
                if (last_bit) begin
                    add_start  = 1'b1;
                    next_state = FINAL;
                end else begin
                    next_state = CHK_A;
                end
            end
            FINAL: if (add_done) next_state = DONE;
            DONE:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Operand latch, accumulator, bit counter and result register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q     <= '0;
            b_q     <= '0;
            m_q     <= '0;
            c_q     <= '0;
            bit_idx <= '0;
            result  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        a_q     <= in_a;
                        b_q     <= in_b;
                        m_q     <= in_m;
                        c_q     <= '0;
                        bit_idx <= '0;
                    end
                end
                ADD_B, ADD_M: if (add_done) c_q <= add_res[N+1:0];
                SHIFT: begin
                    c_q     <= c_q >> 1;
                    bit_idx <= bit_idx + CNT_W'(1);
                end
                // A borrow means C was already below m, so C is the result.
                FINAL: begin
                    if (add_done) result <= add_res[ADDER_W] ? c_q[N-1:0] : add_res[N-1:0];
                end
                default: ;
            endcase
        end
    end

endmodule
